// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
//   Shared encodings for the SRAM time-slot arbiter:
//   - state_t : sequencer states (IDLE plus the four access phases P0..P3)
//   - OWN_*   : owner codes driven on the arbiter's owner port
//   - helper  : is_arb_state() marks the states in which arbitration happens
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_HOST = 2'd3;

  // Arbitration is evaluated while idle and in the last phase of an access,
  // so a new access can start directly after the previous one.
  function automatic logic is_arb_state(state_t s);
    return (s == ST_IDLE) || (s == ST_P3);
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick
//   Combinational priority selection between the three (already masked)
//   requests, plus the registered host starvation counter.
//   Ports:
//     clk48, rst      clock, synchronous active-high reset
//     arb_en          high in cycles where a grant may be issued
//     vid_req         masked video request
//     cpu_req         masked CPU request
//     host_req        masked host request
//     host_pending    raw host request (clears the counter when low)
//     win             winning owner code (OWN_NONE when nobody requests)
module sram_arb_pick
  import sram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       arb_en,
  input  logic       vid_req,
  input  logic       cpu_req,
  input  logic       host_req,
  input  logic       host_pending,
  output logic [1:0] win
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  // Video always wins. Once the CPU has taken STARVE_LIMIT grants while the
  // host was waiting, the host is moved ahead of the CPU (never of video).
  always_comb begin
    win = OWN_NONE;
    if (vid_req)
      win = OWN_VID;
    else if (host_req && (starve_cnt == LIMIT))
      win = OWN_HOST;
    else if (cpu_req)
      win = OWN_CPU;
    else if (host_req)
      win = OWN_HOST;
  end

  // Counts CPU grants issued while the host is waiting; saturates at the
  // limit and restarts whenever the host is served or stops asking.
  always_ff @(posedge clk48) begin
    if (rst)
      starve_cnt <= '0;
    else if (!host_pending)
      starve_cnt <= '0;
    else if (arb_en && (win == OWN_HOST))
      starve_cnt <= '0;
    else if (arb_en && (win == OWN_CPU) && (starve_cnt != LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Time-slot arbiter and sequencer for one asynchronous 512Kx8 SRAM shared by
//   video fetch (read only), the Z80 CPU and a host loader. Each grant runs a
//   fixed 4-phase SRAM cycle (P0 address, P1/P2 write strobe, P3 hold/capture)
//   and finishes with a one-cycle ack and registered read data.
//   Ports:
//     clk48, rst                          clock, synchronous active-high reset
//     vid_req/addr -> vid_ack/rdata       video read port
//     cpu_req/we/addr/wdata -> ack/rdata  CPU port
//     host_req/we/addr/wdata -> ack/rdata host loader port
//     sram_a, sram_d_out, sram_d_oe       SRAM address, write data, data drive
//     sram_d_in                           SRAM data pins, input side
//     sram_we_n                           SRAM write strobe, active low
//     owner                               0 none, 1 video, 2 cpu, 3 host
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW           = 19,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk48,
  input  logic          rst,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] sram_a,
  input  logic [DW-1:0] sram_d_in,
  output logic [DW-1:0] sram_d_out,
  output logic          sram_d_oe,
  output logic          sram_we_n,
  output logic [1:0]    owner
);

  state_t        state, state_next;
  logic [AW-1:0] lat_addr;
  logic          lat_we;
  logic [DW-1:0] lat_wdata;
  logic          arb_en;
  logic          grant;
  logic          m_vid, m_cpu, m_host;
  logic [1:0]    win;

  // Requests seen by the picker: the owner finishing in P3 and any port whose
  // ack is currently high are excluded, so a held req is never double-served.
  always_comb begin
    arb_en = is_arb_state(state);
    m_vid  = arb_en && vid_req  && !vid_ack  && !((state == ST_P3) && (owner == OWN_VID));
    m_cpu  = arb_en && cpu_req  && !cpu_ack  && !((state == ST_P3) && (owner == OWN_CPU));
    m_host = arb_en && host_req && !host_ack && !((state == ST_P3) && (owner == OWN_HOST));
    grant  = (win != OWN_NONE);
  end

  sram_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk48       (clk48),
    .rst         (rst),
    .arb_en      (arb_en),
    .vid_req     (m_vid),
    .cpu_req     (m_cpu),
    .host_req    (m_host),
    .host_pending(host_req),
    .win         (win)
  );

  // Phase sequencing: a grant in IDLE or P3 starts P0, otherwise P3 returns
  // to IDLE; the middle phases always advance.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (grant) state_next = ST_P0;
      ST_P0:   state_next = ST_P1;
      ST_P1:   state_next = ST_P2;
      ST_P2:   state_next = ST_P3;
      ST_P3:   state_next = grant ? ST_P0 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, owner and request latches. The requester only holds its
  // address/data up to the grant edge, so everything is captured there. The
  // write strobe is registered so it cannot glitch on the SRAM pin; it is low
  // in the cycles following P0 and P1, i.e. exactly during P1 and P2.
  always_ff @(posedge clk48) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_NONE;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      sram_we_n <= 1'b1;
    end else begin
      state     <= state_next;
      sram_we_n <= !(lat_we && ((state == ST_P0) || (state == ST_P1)));
      if (grant) begin
        owner <= win;
        unique case (win)
          OWN_VID: begin
            lat_addr <= vid_addr;
            lat_we   <= 1'b0;
          end
          OWN_CPU: begin
            lat_addr  <= cpu_addr;
            lat_we    <= cpu_we;
            lat_wdata <= cpu_wdata;
          end
          OWN_HOST: begin
            lat_addr  <= host_addr;
            lat_we    <= host_we;
            lat_wdata <= host_wdata;
          end
          default: ;
        endcase
      end else if (state == ST_P3) begin
        owner <= OWN_NONE;
      end
    end
  end

  // Completion: the edge ending P3 raises the owner's ack for one cycle and,
  // for reads, captures the SRAM data into that port's rdata register.
  always_ff @(posedge clk48) begin
    if (rst) begin
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      vid_rdata  <= '0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      vid_ack  <= (state == ST_P3) && (owner == OWN_VID);
      cpu_ack  <= (state == ST_P3) && (owner == OWN_CPU);
      host_ack <= (state == ST_P3) && (owner == OWN_HOST);
      if ((state == ST_P3) && !lat_we) begin
        unique case (owner)
          OWN_VID:  vid_rdata  <= sram_d_in;
          OWN_CPU:  cpu_rdata  <= sram_d_in;
          OWN_HOST: host_rdata <= sram_d_in;
          default: ;
        endcase
      end
    end
  end

  // Video grants clear lat_we, so the data bus is never driven for video.
  assign sram_a     = lat_addr;
  assign sram_d_out = lat_wdata;
  assign sram_d_oe  = lat_we && (state != ST_IDLE);

endmodule
